// File: rtl/adder_accum_ctrl_pkg.sv
// rtl/adder_accum_ctrl_pkg.sv - shared types and constants for the adder accumulation controller
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int TREE_W = 20;
    localparam int BUS_W  = LANES * LANE_W;

endpackage

// File: rtl/adder_accum_ctrl_if.sv
// rtl/adder_accum_ctrl_if.sv - job control, beat input and result output bundle
interface adder_accum_ctrl_if
    import tpu_pkg::*;
#(
    parameter int BEAT_W = 8,
    parameter int ACC_W  = 28
);
    logic              start;
    logic [BEAT_W-1:0] num_beats;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              busy;

    modport master (
        output start, num_beats, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, num_beats, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/adder_accum_ctrl_adder_tree.sv
// rtl/adder_accum_ctrl_adder_tree.sv - combinational 16-lane signed 16-bit to 20-bit reduction
module ADDER_16b_20b
    import tpu_pkg::*;
(
    input  logic [BUS_W-1:0]         ain,
    output logic signed [TREE_W-1:0] aout
);
    // 16 x 2^15 fits in 20 signed bits, so the running sum never wraps
    always_comb begin
        logic [LANE_W-1:0] lane;
        logic [TREE_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = ain[i*LANE_W +: LANE_W];
            sum  = sum + {{(TREE_W-LANE_W){lane[LANE_W-1]}}, lane};
        end
        aout = sum;
    end
endmodule

// File: rtl/adder_accum_ctrl.sv
// rtl/adder_accum_ctrl.sv - sequences the adder tree over an N-beat job and accumulates a signed total
module adder_accum_ctrl
    import tpu_pkg::*;
#(
    parameter int BEAT_W = 8,
    parameter int ACC_W  = 28
)(
    input  logic              clk,
    input  logic              reset_n,
    adder_accum_ctrl_if.slave bus
);
    state_t                  state;
    state_t                  state_nx;
    logic [BEAT_W-1:0]       rem;
    logic [ACC_W-1:0]        acc;
    logic signed [TREE_W-1:0] adder_sum;
    logic                    busy_q;
    logic                    in_ready;
    logic                    out_valid;
    logic                    start_ok;
    logic                    in_xfer;

    ADDER_16b_20b u_tree (
        .ain  (bus.in_data),
        .aout (adder_sum)
    );

    // abort has priority over a start arriving in the same IDLE cycle
    assign start_ok = (state == IDLE) && bus.start && !bus.abort;
    assign in_xfer  = (state == ACCUM) && bus.in_valid && !bus.abort;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok)
                    state_nx = (bus.num_beats == '0) ? OUTPUT : ACCUM;
            end
            ACCUM: begin
                if (bus.abort)
                    state_nx = IDLE;
                else if (bus.in_valid && rem == BEAT_W'(1))
                    state_nx = OUTPUT;
            end
            OUTPUT: begin
                if (bus.abort || bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM:   in_ready  = 1'b1;
            OUTPUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ACC_W >= TREE_W + BEAT_W, so the sign-extended sum cannot overflow acc
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
            rem <= '0;
        end else if (start_ok) begin
            acc <= '0;
            rem <= bus.num_beats;
        end else if (bus.abort && state != IDLE) begin
            acc <= '0;
            rem <= '0;
        end else if (in_xfer) begin
            acc <= acc + {{(ACC_W-TREE_W){adder_sum[TREE_W-1]}}, adder_sum};
            rem <= rem - BEAT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = acc;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_adder_accum_ctrl.sv
// tb/tb_adder_accum_ctrl.sv - self-checking bench for adder_accum_ctrl
module tb_adder_accum_ctrl;
    import tpu_pkg::*;

    localparam int ACC_W = 28;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    logic [BUS_W-1:0] beats[$];

    always #5 clk = ~clk;

    adder_accum_ctrl_if #(.BEAT_W(8), .ACC_W(ACC_W)) bus ();

    adder_accum_ctrl #(.BEAT_W(8), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [BUS_W-1:0] const_beat(input int v);
        logic [BUS_W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = v[LANE_W-1:0];
        return w;
    endfunction

    function automatic logic [BUS_W-1:0] rand_beat();
        logic [BUS_W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = LANE_W'($urandom_range(0, 65535));
        return w;
    endfunction

    function automatic longint beat_sum(input logic [BUS_W-1:0] w);
        longint s = 0;
        for (int i = 0; i < LANES; i++) s += longint'($signed(w[i*LANE_W +: LANE_W]));
        return s;
    endfunction

    function automatic longint model_total(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += beat_sum(beats[i]);
        return s;
    endfunction

    function automatic longint got_data();
        return longint'($signed(bus.out_data));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one job; returns the result, edges from start edge to out_valid, stall stability
    task automatic run_job(input int n, input int valid_pct, input int stall, input bit mid_start,
                           output longint result, output int latency, output bit held_ok,
                           output bit timeout);
        int idx = 0;
        int budget = 0;
        bit pulsed = 0;
        logic [ACC_W-1:0] first;
        result = 0; latency = 0; held_ok = 1; timeout = 0;
        bus.start = 1'b1;
        bus.num_beats = n[7:0];
        tick();
        bus.start = 1'b0;
        while (!bus.out_valid && budget < 3000) begin
            if (mid_start && !pulsed && idx == 2) begin
                bus.start = 1'b1; bus.num_beats = 8'd1; pulsed = 1;
            end else begin
                bus.start = 1'b0;
            end
            if (idx < n && $urandom_range(0, 99) < valid_pct) begin
                bus.in_valid = 1'b1; bus.in_data = beats[idx];
            end else begin
                bus.in_valid = 1'b0; bus.in_data = rand_beat();
            end
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
            latency++; budget++;
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        if (budget >= 3000) begin
            timeout = 1;
            return;
        end
        first = bus.out_data;
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (!bus.out_valid || bus.out_data !== first) held_ok = 0;
        end
        result = longint'($signed(first));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", got_data()); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        longint r; int lat; bit held, to;
        // stray beats in IDLE must not be consumed
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin bus.in_data = rand_beat(); tick(); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL idle_ignores_in_valid got ready=%b busy=%b exp=0,0", bus.in_ready, bus.busy); end
        bus.in_valid = 1'b0;
        beats = {const_beat(1)};
        run_job(1, 100, 0, 0, r, lat, held, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", to); end
        checks++; if (r !== 64'sd16) begin failures++; $display("FAIL single_data got=%0d exp=16", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", lat); end
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_idle_after got busy=%b valid=%b exp=0,0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_signed_extremes();
        longint r; int lat; bit held, to;
        int vals[2] = '{-32768, 32767};
        foreach (vals[k]) begin
            beats.delete();
            for (int i = 0; i < 255; i++) beats.push_back(const_beat(vals[k]));
            run_job(255, 100, 0, 0, r, lat, held, to);
            checks++; if (r !== model_total(255) || to) begin failures++; $display("FAIL extreme_%0d got=%0d exp=%0d", vals[k], r, model_total(255)); end
            checks++; if (lat !== 255) begin failures++; $display("FAIL extreme_latency_%0d got=%0d exp=255", vals[k], lat); end
        end
    endtask

    task automatic test_backpressure();
        longint r; int lat; bit held, to;
        logic [BUS_W-1:0] b0, b1, b2;
        b0 = '0; b1 = '0; b2 = '0;
        for (int i = 0; i < 5; i++) b0[i*LANE_W +: LANE_W] = 16'd1;
        b1[3*LANE_W +: LANE_W] = 16'hFFFE;
        b2[15*LANE_W +: LANE_W] = 16'd10;
        beats = {b0, b1, b2};
        run_job(3, 50, 7, 0, r, lat, held, to);
        checks++; if (r !== 64'sd13 || to) begin failures++; $display("FAIL backpressure_data got=%0d exp=13", r); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL backpressure_hold got=%b exp=1", held); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL backpressure_idle got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_zero_length();
        bus.start = 1'b1; bus.num_beats = 8'd0; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== '0) begin failures++; $display("FAIL zero_len got valid=%b data=%0d exp=1,0", bus.out_valid, got_data()); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL zero_len_in_ready got=%b exp=0", bus.in_ready); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_start_while_busy();
        longint r; int lat; bit held, to;
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back(rand_beat());
        run_job(4, 100, 2, 1, r, lat, held, to);
        checks++; if (r !== model_total(4) || lat !== 4 || to) begin failures++; $display("FAIL start_busy got=%0d lat=%0d exp=%0d lat=4", r, lat, model_total(4)); end
    endtask

    task automatic test_abort();
        longint r; int lat; bit held, to;
        bit seen = 0;
        bus.start = 1'b1; bus.num_beats = 8'd4;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin bus.in_data = rand_beat(); tick(); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_accum got busy=%b ready=%b valid=%b exp=0,0,0", bus.busy, bus.in_ready, bus.out_valid); end
        for (int i = 0; i < 5; i++) begin tick(); if (bus.out_valid) seen = 1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_output got=%b exp=0", seen); end
        beats = {const_beat(2)};
        run_job(1, 100, 0, 0, r, lat, held, to);
        checks++; if (r !== 64'sd32 || to) begin failures++; $display("FAIL abort_no_stale got=%0d exp=32", r); end
        // start together with abort in IDLE
        bus.start = 1'b1; bus.abort = 1'b1; bus.num_beats = 8'd3;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL start_abort_idle got busy=%b ready=%b exp=0,0", bus.busy, bus.in_ready); end
        // abort stalled in OUTPUT, then abort coincident with the transfer
        for (int k = 0; k < 2; k++) begin
            bus.start = 1'b1; bus.num_beats = 8'd0;
            tick();
            bus.start = 1'b0; bus.abort = 1'b1; bus.out_ready = (k == 1);
            tick();
            bus.abort = 1'b0; bus.out_ready = 1'b0;
            checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_output_%0d got valid=%b busy=%b exp=0,0", k, bus.out_valid, bus.busy); end
        end
    endtask

    task automatic test_reset_in_output();
        bus.start = 1'b1; bus.num_beats = 8'd1;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = const_beat(3);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 28'd48) begin failures++; $display("FAIL pre_reset_output got valid=%b data=%0d exp=1,48", bus.out_valid, got_data()); end
        reset_n = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_in_output got valid=%b data=%0d ready=%b busy=%b exp=0", bus.out_valid, got_data(), bus.in_ready, bus.busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random_jobs();
        longint r; int lat; bit held, to;
        for (int j = 0; j < 12; j++) begin
            int n = $urandom_range(1, 24);
            int pct = $urandom_range(30, 100);
            int st = $urandom_range(0, 4);
            beats.delete();
            for (int i = 0; i < n; i++) beats.push_back(rand_beat());
            run_job(n, pct, st, 0, r, lat, held, to);
            checks++; if (r !== model_total(n) || !held || to) begin failures++; $display("FAIL random_job_%0d n=%0d got=%0d held=%b exp=%0d", j, n, r, held, model_total(n)); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.num_beats = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_signed_extremes();
        test_backpressure();
        test_zero_length();
        test_start_while_busy();
        test_abort();
        test_reset_in_output();
        test_random_jobs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
